dtpu_mxu_sequencer: RTL and testbench
=====================================

// Module: dtpu_mxu_sequencer
// PURPOSE
// Control FSM between the dtpu_core control interface (cs_*) and the MXU datapath.
// On cs_start it loads one weight tile from weight memory into the MXU, streams N input vectors
// from the input FIFO through the array, then drains results into the output FIFO.
// Output-FIFO backpressure stalls the whole array globally. Tile config is latched from CSR-driven inputs.
// PARAMETERS
// ROWS               8    MXU rows = weight words per tile
// COLUMNS            8    MXU columns
// DATA_WIDTH_WMEMORY 64   weight word width (COLUMNS*8)
// ADDR_WIDTH         32   weight memory address width
// CNT_WIDTH          16   vector counter width
// PIPE_LATENCY       ROWS+COLUMNS-1  array shifts from input accept to result out
// PORTS
// clk            in  1    single clock, rising edge
// aresetn        in  1    asynchronous active-low reset
// enable         in  1    0 = freeze: FSM/counters hold, all strobes 0
// cs_start       in  1    start request, sampled only in IDLE
// cs_continue    in  1    acknowledge of done, returns FSM to IDLE
// cs_done        out 1    high throughout DONE
// cs_idle        out 1    high in IDLE
// cs_ready       out 1    high in IDLE (start accepted)
// cfg_wm_base    in  ADDR_WIDTH  tile base address, latched on start
// cfg_n_vectors  in  CNT_WIDTH   vectors to stream, latched on start
// wm_address     out ADDR_WIDTH  weight memory address
// wm_ce          out 1    weight memory read enable
// wm_we          out 1    constant 0
// wm_dout        in  DATA_WIDTH_WMEMORY  read data, 1-cycle latency after wm_ce
// mxu_load_weight out 1   load wm_dout into row mxu_weight_idx
// mxu_weight_idx out $clog2(ROWS)  target row
// mxu_weight_row out DATA_WIDTH_WMEMORY  = wm_dout (combinational pass)
// mxu_shift      out 1    advance the array one step
// mxu_in_valid   out 1    current shift carries a FIFO vector (else feed zeros)
// infifo_is_empty in 1 ; infifo_read out 1
// outfifo_is_full in 1 ; outfifo_write out 1
// state          out 4    IDLE=0 LOAD_W=1 STREAM=2 DRAIN=3 DONE=4
// BEHAVIOUR
// - Reset: state=IDLE, counters/valid pipe 0, wm_address 0, all strobes 0, cs_idle=cs_ready=1, cs_done=0.
// - IDLE: on enable&cs_start latch cfg_*, clear counters -> LOAD_W.
// - LOAD_W: ROWS cycles, wm_ce=1, wm_address=base+i, i=0..ROWS-1; next cycle mxu_load_weight=1,
//   mxu_weight_idx=i. Exit after last load strobe (ROWS+1 cycles): N=0 -> DONE, else STREAM.
// - adv = enable & !outfifo_is_full. STREAM: issue = adv & !infifo_is_empty & issued<N;
//   infifo_read=mxu_shift=mxu_in_valid=issue; issued++ on issue. issued==N -> DRAIN.
//   STREAM with no issue: mxu_shift=0 (no bubbles inserted).
// - DRAIN: mxu_shift=adv, mxu_in_valid=0, infifo_read=0.
// - Valid pipe: PIPE_LATENCY-deep shift reg, shifts in mxu_in_valid only when mxu_shift=1.
//   outfifo_write = mxu_shift & pipe[last]; written++ on write. written==N -> DONE.
// - outfifo_write never asserted when outfifo_is_full (implied by adv).
// - DONE: cs_done=1 until cs_continue=1 -> IDLE. cs_start ignored outside IDLE.
// - Counters never wrap: compare issued/written against latched N only.
// - enable=0 in any state: full freeze, resume exactly where left.
// - aresetn low mid-operation: immediate return to reset values; partial tile discarded.
// TESTING
// 1 Reset: aresetn=0 -> state=0, cs_idle=cs_ready=1, wm_ce/infifo_read/outfifo_write/mxu_* =0.
// 2 base=0x40,N=4, FIFO non-empty, out not full: wm_address 0x40..0x47 on 8 cycles; load idx 0..7
//   one cycle later; 4 consecutive infifo_read; first outfifo_write at 15th shift after first read;
//   4 writes; cs_done=1; cs_continue -> IDLE.
// 3 N=6, infifo_is_empty toggling every 2 cycles -> reads only when non-empty, exactly 6 reads, 6 writes.
// 4 N=20, outfifo_is_full=1 for 20 cycles mid-STREAM -> mxu_shift/infifo_read/outfifo_write all 0; resume, 20 writes, none lost.
// 5 N=0 -> LOAD_W completes (8 reads), then DONE, no FIFO activity.
// 6 enable=0 for 10 cycles in DRAIN -> outputs frozen; aresetn pulse mid-STREAM -> IDLE, counters 0, restart clean.

Source files
------------

// File: rtl/dtpu_mxu_sequencer_if.sv
// Control and datapath bundle between the MXU sequencer and its environment:
// dtpu_core control handshake, weight memory port, MXU strobes and FIFO flags.
`timescale 1ns/1ps
interface dtpu_mxu_sequencer_if #(
   parameter int ROWS               = 8,
   parameter int DATA_WIDTH_WMEMORY = 64,
   parameter int ADDR_WIDTH         = 32,
   parameter int CNT_WIDTH          = 16
);
   localparam int IDX_WIDTH = (ROWS > 1) ? $clog2(ROWS) : 1;

   // dtpu_core control interface
   logic                          cs_start;
   logic                          cs_continue;
   logic                          cs_done;
   logic                          cs_idle;
   logic                          cs_ready;
   logic [ADDR_WIDTH-1:0]         cfg_wm_base;
   logic [CNT_WIDTH-1:0]          cfg_n_vectors;

   // weight memory read port
   logic [ADDR_WIDTH-1:0]         wm_address;
   logic                          wm_ce;
   logic                          wm_we;
   logic [DATA_WIDTH_WMEMORY-1:0] wm_dout;

   // MXU datapath controls
   logic                          mxu_load_weight;
   logic [IDX_WIDTH-1:0]          mxu_weight_idx;
   logic [DATA_WIDTH_WMEMORY-1:0] mxu_weight_row;
   logic                          mxu_shift;
   logic                          mxu_in_valid;

   // input / output FIFO handshake
   logic                          infifo_is_empty;
   logic                          infifo_read;
   logic                          outfifo_is_full;
   logic                          outfifo_write;

   // sequencer side
   modport master (
      input  cs_start, cs_continue, cfg_wm_base, cfg_n_vectors,
      input  wm_dout, infifo_is_empty, outfifo_is_full,
      output cs_done, cs_idle, cs_ready,
      output wm_address, wm_ce, wm_we,
      output mxu_load_weight, mxu_weight_idx, mxu_weight_row, mxu_shift, mxu_in_valid,
      output infifo_read, outfifo_write
   );

   // environment side (core, memory, MXU, FIFOs)
   modport slave (
      output cs_start, cs_continue, cfg_wm_base, cfg_n_vectors,
      output wm_dout, infifo_is_empty, outfifo_is_full,
      input  cs_done, cs_idle, cs_ready,
      input  wm_address, wm_ce, wm_we,
      input  mxu_load_weight, mxu_weight_idx, mxu_weight_row, mxu_shift, mxu_in_valid,
      input  infifo_read, outfifo_write
   );
endinterface

// File: rtl/dtpu_mxu_sequencer.sv
// MXU sequencer: loads one weight tile, streams N input vectors through the
// systolic array and drains N results, stalling globally on output backpressure.
`timescale 1ns/1ps
module dtpu_mxu_sequencer #(
   parameter int ROWS               = 8,
   parameter int COLUMNS            = 8,
   parameter int DATA_WIDTH_WMEMORY = 64,
   parameter int ADDR_WIDTH         = 32,
   parameter int CNT_WIDTH          = 16
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   enable,
   output logic [3:0]             state,
   dtpu_mxu_sequencer_if.master   bus
);
   localparam int PIPE_LATENCY = ROWS + COLUMNS - 1;
   localparam int IDX_WIDTH    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int LD_WIDTH     = $clog2(ROWS + 1);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_LOAD_W = 4'd1;
   localparam logic [3:0] S_STREAM = 4'd2;
   localparam logic [3:0] S_DRAIN  = 4'd3;
   localparam logic [3:0] S_DONE   = 4'd4;

   logic [ADDR_WIDTH-1:0]   wm_base;
   logic [CNT_WIDTH-1:0]    n_vectors;
   logic [CNT_WIDTH-1:0]    issued;
   logic [CNT_WIDTH-1:0]    written;
   logic [LD_WIDTH-1:0]     ld_cnt;
   logic [LD_WIDTH-1:0]     ld_prev;
   logic [PIPE_LATENCY-1:0] valid_pipe;
   logic                    start_accept;
   logic                    adv;
   logic                    issue;
   logic                    shift;
   logic                    write;

   // Array advance / issue / retire decisions for the current cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      start_accept = 1'b0;
      adv          = 1'b0;
      issue        = 1'b0;
      shift        = 1'b0;
      write        = 1'b0;
      ld_prev      = ld_cnt - LD_WIDTH'(1);

      start_accept = enable & (state == S_IDLE) & bus.cs_start;
      adv          = enable & ~bus.outfifo_is_full;
      issue        = (state == S_STREAM) & adv & ~bus.infifo_is_empty & (issued < n_vectors);
      shift        = issue | ((state == S_DRAIN) & adv);
      // A result leaves the array only on a shift, and shifts require a non-full output FIFO.
      write        = shift & valid_pipe[PIPE_LATENCY-1];
   end

   // Control handshake, weight memory port and MXU strobes.
   assign bus.cs_idle         = (state == S_IDLE);
   assign bus.cs_ready        = (state == S_IDLE);
   assign bus.cs_done         = (state == S_DONE);
   assign bus.wm_we           = 1'b0;
   assign bus.wm_ce           = enable & (state == S_LOAD_W) & (ld_cnt < LD_WIDTH'(ROWS));
   assign bus.wm_address      = (state == S_LOAD_W) ? wm_base + ADDR_WIDTH'(ld_cnt) : '0;
   // Memory data arrives one cycle after its read, so the load targets the previous row index.
   assign bus.mxu_load_weight = enable & (state == S_LOAD_W) & (ld_cnt != '0);
   assign bus.mxu_weight_idx  = ld_prev[IDX_WIDTH-1:0];
   assign bus.mxu_weight_row  = bus.wm_dout;
   assign bus.mxu_shift       = shift;
   assign bus.mxu_in_valid    = issue;
   assign bus.infifo_read     = issue;
   assign bus.outfifo_write   = write;

   // Sequencer FSM: tile config latch, weight-load counter and phase transitions.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= S_IDLE;
         wm_base   <= '0;
         n_vectors <= '0;
         ld_cnt    <= '0;
      end else if (enable) begin
         // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
         case (state)
            S_IDLE: begin
               if (bus.cs_start) begin
                  wm_base   <= bus.cfg_wm_base;
                  n_vectors <= bus.cfg_n_vectors;
                  ld_cnt    <= '0;
                  state     <= S_LOAD_W;
               end
            end
            S_LOAD_W: begin
               if (ld_cnt == LD_WIDTH'(ROWS)) begin
                  state <= (n_vectors == '0) ? S_DONE : S_STREAM;
               end else begin
                  ld_cnt <= ld_cnt + LD_WIDTH'(1);
               end
            end
            S_STREAM: begin
               if (issue && (issued + CNT_WIDTH'(1) == n_vectors)) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (write && (written + CNT_WIDTH'(1) == n_vectors)) state <= S_DONE;
            end
            S_DONE: begin
               if (bus.cs_continue) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Issue/retire counters and the valid pipe that tracks vectors inside the array.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         issued     <= '0;
         written    <= '0;
         valid_pipe <= '0;
      end else if (start_accept) begin
         issued     <= '0;
         written    <= '0;
         valid_pipe <= '0;
      end else begin
         if (issue) issued  <= issued + CNT_WIDTH'(1);
         if (write) written <= written + CNT_WIDTH'(1);
         if (shift) valid_pipe <= {valid_pipe[PIPE_LATENCY-2:0], issue};
      end
   end
endmodule

// File: tb/tb_dtpu_mxu_sequencer.sv
// Directed self-checking bench for dtpu_mxu_sequencer: reset state, full tile
// run, empty-FIFO gaps, output backpressure, empty tile, freeze and mid-run reset.
`timescale 1ns/1ps
module tb_dtpu_mxu_sequencer;
   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int DW   = 64;
   localparam int AW   = 32;
   localparam int CW   = 16;

   logic       clk = 1'b0;
   logic       aresetn = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] state;

   dtpu_mxu_sequencer_if #(.ROWS(ROWS), .DATA_WIDTH_WMEMORY(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   dtpu_mxu_sequencer #(
      .ROWS(ROWS), .COLUMNS(COLS), .DATA_WIDTH_WMEMORY(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
   ) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .enable  (enable),
      .state   (state),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   // Weight memory model: one-cycle read latency, data derived from the address.
   always @(posedge clk) begin
      if (bus.wm_ce) bus.wm_dout <= {~bus.wm_address, bus.wm_address};
   end

   int checks = 0;
   int errors = 0;
   int cyc, ce_n, ld_n, rd_n, wr_n, sh_n;
   int first_rd_sh, first_wr_sh, first_rd_cyc, last_rd_cyc;
   int bad_empty, bad_full, bad_freeze, stall_stream;
   logic [AW-1:0] ce_addr[$];
   int            ce_cyc[$];
   int            ld_cyc[$];
   int            ld_idx[$];
   logic [DW-1:0] ld_row[$];
   bit            toggle_empty;
   int            full_from, full_len;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      cyc = 0; ce_n = 0; ld_n = 0; rd_n = 0; wr_n = 0; sh_n = 0;
      first_rd_sh = -1; first_wr_sh = -1; first_rd_cyc = -1; last_rd_cyc = -1;
      bad_empty = 0; bad_full = 0; bad_freeze = 0; stall_stream = 0;
      ce_addr.delete(); ce_cyc.delete(); ld_cyc.delete(); ld_idx.delete(); ld_row.delete();
      toggle_empty = 1'b0; full_from = 0; full_len = 0;
   endtask

   // Called just after a falling edge with inputs set: record this cycle's strobes, move to next falling edge.
   task automatic clk_cycle();
      #1;
      if (bus.wm_ce) begin
         ce_n++; ce_addr.push_back(bus.wm_address); ce_cyc.push_back(cyc);
      end
      if (bus.mxu_load_weight) begin
         ld_n++; ld_idx.push_back(int'(bus.mxu_weight_idx));
         ld_row.push_back(bus.mxu_weight_row); ld_cyc.push_back(cyc);
      end
      if (bus.mxu_shift) sh_n++;
      if (bus.infifo_read) begin
         rd_n++;
         if (first_rd_sh < 0) first_rd_sh = sh_n;
         if (first_rd_cyc < 0) first_rd_cyc = cyc;
         last_rd_cyc = cyc;
      end
      if (bus.outfifo_write) begin
         wr_n++;
         if (first_wr_sh < 0) first_wr_sh = sh_n;
      end
      if (bus.infifo_read && bus.infifo_is_empty) bad_empty++;
      if (bus.outfifo_is_full && (bus.mxu_shift || bus.infifo_read || bus.outfifo_write)) bad_full++;
      if (bus.outfifo_is_full && state == 4'd2) stall_stream++;
      if (!enable && (bus.wm_ce || bus.mxu_load_weight || bus.mxu_shift || bus.mxu_in_valid ||
                      bus.infifo_read || bus.outfifo_write)) bad_freeze++;
      cyc++;
      @(negedge clk);
   endtask

   task automatic start(input logic [AW-1:0] base, input logic [CW-1:0] n);
      bus.cfg_wm_base   = base;
      bus.cfg_n_vectors = n;
      bus.cs_start      = 1'b1;
      clk_cycle();
      bus.cs_start      = 1'b0;
   endtask

   task automatic run_to_done(input int budget, input string tag);
      int n = 0;
      while (!bus.cs_done && n < budget) begin
         if (toggle_empty) bus.infifo_is_empty = ((n / 2) % 2) == 1;
         if (full_len > 0) bus.outfifo_is_full = (n >= full_from) && (n < full_from + full_len);
         clk_cycle();
         n++;
      end
      bus.infifo_is_empty = 1'b0;
      bus.outfifo_is_full = 1'b0;
      check($sformatf("%s done reached", tag), bus.cs_done, 1);
   endtask

   task automatic acknowledge(input string tag);
      bus.cs_continue = 1'b1;
      clk_cycle();
      bus.cs_continue = 1'b0;
      check($sformatf("%s back to idle", tag), state, 0);
   endtask

   initial begin
      logic [AW-1:0] a;
      int            n;
      int            wr_before;
      bus.cs_start = 1'b0; bus.cs_continue = 1'b0;
      bus.cfg_wm_base = '0; bus.cfg_n_vectors = '0;
      bus.infifo_is_empty = 1'b0; bus.outfifo_is_full = 1'b0;
      clear_stats();

      // 1: reset state
      #3;
      check("rst state", state, 0);
      check("rst cs_idle", bus.cs_idle, 1);
      check("rst cs_ready", bus.cs_ready, 1);
      check("rst cs_done", bus.cs_done, 0);
      check("rst wm_ce", bus.wm_ce, 0);
      check("rst wm_we", bus.wm_we, 0);
      check("rst wm_address", bus.wm_address, 0);
      check("rst infifo_read", bus.infifo_read, 0);
      check("rst outfifo_write", bus.outfifo_write, 0);
      check("rst mxu strobes", {bus.mxu_shift, bus.mxu_in_valid, bus.mxu_load_weight}, 0);
      @(negedge clk);
      aresetn = 1'b1;
      enable  = 1'b1;
      clk_cycle();

      // 2: base 0x40, N=4, free-flowing FIFOs
      clear_stats();
      start(32'h40, 16'd4);
      run_to_done(200, "t2");
      check("t2 wm_ce count", ce_n, ROWS);
      check("t2 load count", ld_n, ROWS);
      for (int i = 0; i < ROWS; i++) begin
         a = 32'h40 + AW'(i);
         if (i < ce_addr.size()) check($sformatf("t2 wm_address[%0d]", i), ce_addr[i], a);
         if (i < ld_idx.size()) begin
            check($sformatf("t2 load idx[%0d]", i), ld_idx[i], i);
            check($sformatf("t2 load row[%0d]", i), ld_row[i], {~a, a});
            check($sformatf("t2 load delay[%0d]", i), ld_cyc[i] - ce_cyc[i], 1);
         end
      end
      check("t2 reads", rd_n, 4);
      check("t2 reads consecutive", last_rd_cyc - first_rd_cyc, 3);
      check("t2 writes", wr_n, 4);
      check("t2 first write shift offset", first_wr_sh - first_rd_sh, 15);
      check("t2 state done", state, 4);
      bus.cs_start = 1'b1;
      clk_cycle();
      bus.cs_start = 1'b0;
      check("t2 start ignored in done", state, 4);
      check("t2 cs_ready in done", bus.cs_ready, 0);
      acknowledge("t2");

      // 3: N=6, input FIFO empty every other pair of cycles
      clear_stats();
      start(32'h0, 16'd6);
      toggle_empty = 1'b1;
      run_to_done(300, "t3");
      check("t3 reads", rd_n, 6);
      check("t3 writes", wr_n, 6);
      check("t3 read while empty", bad_empty, 0);
      acknowledge("t3");

      // 4: N=20, output FIFO full for 20 cycles mid-stream
      clear_stats();
      start(32'h200, 16'd20);
      full_from = 14;
      full_len  = 20;
      run_to_done(400, "t4");
      check("t4 stalled stream cycles", stall_stream, 20);
      check("t4 activity while full", bad_full, 0);
      check("t4 reads", rd_n, 20);
      check("t4 writes", wr_n, 20);
      acknowledge("t4");

      // 5: N=0, weights only
      clear_stats();
      start(32'h80, 16'd0);
      run_to_done(100, "t5");
      check("t5 wm_ce count", ce_n, ROWS);
      check("t5 load count", ld_n, ROWS);
      check("t5 reads", rd_n, 0);
      check("t5 writes", wr_n, 0);
      check("t5 shifts", sh_n, 0);
      acknowledge("t5");

      // 6a: freeze for 10 cycles in DRAIN
      clear_stats();
      start(32'h0, 16'd4);
      n = 0;
      while (state !== 4'd3 && n < 100) begin
         clk_cycle();
         n++;
      end
      check("t6 reached drain", state, 3);
      wr_before = wr_n;
      enable = 1'b0;
      for (int i = 0; i < 10; i++) clk_cycle();
      check("t6 frozen state", state, 3);
      check("t6 strobes while frozen", bad_freeze, 0);
      check("t6 writes while frozen", wr_n, wr_before);
      enable = 1'b1;
      run_to_done(200, "t6");
      check("t6 writes after resume", wr_n, 4);
      acknowledge("t6");

      // 6b: reset pulse mid-stream, then a clean restart
      clear_stats();
      bus.infifo_is_empty = 1'b0;
      start(32'h0, 16'd20);
      n = 0;
      while (state !== 4'd2 && n < 100) begin
         clk_cycle();
         n++;
      end
      for (int i = 0; i < 3; i++) clk_cycle();
      check("t6 in stream before reset", state, 2);
      aresetn = 1'b0;
      #1;
      check("t6 reset state", state, 0);
      check("t6 reset cs_idle", bus.cs_idle, 1);
      check("t6 reset issued", dut.issued, 0);
      check("t6 reset written", dut.written, 0);
      check("t6 reset strobes", {bus.infifo_read, bus.mxu_shift, bus.outfifo_write, bus.wm_ce}, 0);
      @(negedge clk);
      aresetn = 1'b1;
      clear_stats();
      start(32'h100, 16'd3);
      run_to_done(200, "t6r");
      check("t6r wm_ce count", ce_n, ROWS);
      if (ce_addr.size() > 0) check("t6r first address", ce_addr[0], 32'h100);
      check("t6r reads", rd_n, 3);
      check("t6r writes", wr_n, 3);
      acknowledge("t6r");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
